// File: rtl/arith_pkg.sv
// ----------------------------------------------------------------------------
// arith_pkg
// Shared definitions for the digit-serial arithmetic blocks.
//   state_e         : control FSM states of the serial subtractor
//   step_cnt_width  : width of a step counter covering 0..nstep-1 (minimum 1)
// ----------------------------------------------------------------------------
package arith_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

    // A single-step operation still needs a 1-bit counter so the register
    // declaration never collapses to zero width.
    function automatic int unsigned step_cnt_width(input int unsigned nstep);
        if (nstep <= 1) begin
            return 1;
        end
        return $clog2(nstep);
    endfunction

endpackage

// File: rtl/fs_digit.sv
// ----------------------------------------------------------------------------
// fs_digit
// Purely combinational DIGIT-bit ripple subtractor built from full-subtractor
// bit cells: d = a ^ b ^ bin, bout = (~a & b) | ((~a | b) & bin).
// Ports:
//   i_a    [DIGIT-1:0]  minuend digit
//   i_b    [DIGIT-1:0]  subtrahend digit
//   i_bin               borrow into bit 0
//   o_d    [DIGIT-1:0]  difference digit
//   o_bout              borrow out of bit DIGIT-1
// ----------------------------------------------------------------------------
module fs_digit #(
    parameter int unsigned DIGIT = 4
) (
    input  logic [DIGIT-1:0] i_a,
    input  logic [DIGIT-1:0] i_b,
    input  logic             i_bin,
    output logic [DIGIT-1:0] o_d,
    output logic             o_bout
);

    logic [DIGIT:0] w_borrow;

    always_comb begin
        w_borrow    = '0;
        o_d         = '0;
        w_borrow[0] = i_bin;
        for (int unsigned i = 0; i < DIGIT; i++) begin
            o_d[i]        = i_a[i] ^ i_b[i] ^ w_borrow[i];
            w_borrow[i+1] = (~i_a[i] & i_b[i]) | ((~i_a[i] | i_b[i]) & w_borrow[i]);
        end
        o_bout = w_borrow[DIGIT];
    end

endmodule

// File: rtl/serial_subtractor.sv
// ----------------------------------------------------------------------------
// serial_subtractor
// Digit-serial WIDTH-bit subtractor: diff = a - b - bin (mod 2^WIDTH), computed
// DIGIT bits per clock over NSTEP = WIDTH/DIGIT cycles through one reused
// fs_digit slice and a registered borrow. Also reports the final borrow and
// signed two's-complement overflow.
// Ports:
//   i_clk, i_rst_n    clock (rising edge), asynchronous active-low reset
//   i_start           request; sampled only in IDLE or DONE
//   i_a, i_b, i_bin   operands, captured on the accepting edge
//   o_busy            high while the digit loop runs
//   o_done            one-cycle pulse when results become valid
//   o_diff            result register, held until the next completion
//   o_bout            final borrow out of bit WIDTH-1 (unsigned a < b + bin)
//   o_ovf             signed overflow of a - b - bin
// ----------------------------------------------------------------------------
module serial_subtractor
    import arith_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DIGIT = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_bin,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_diff,
    output logic             o_bout,
    output logic             o_ovf
);

    localparam int unsigned NStep = WIDTH / DIGIT;
    localparam int unsigned CntW  = step_cnt_width(NStep);
    localparam logic [CntW-1:0] LastStep = CntW'(NStep - 1);

    // Elaboration-time parameter checks.
    if (DIGIT < 1 || DIGIT > WIDTH) begin : g_bad_digit
        $error("serial_subtractor: DIGIT must satisfy 1 <= DIGIT <= WIDTH");
    end
    if (WIDTH % DIGIT != 0) begin : g_bad_ratio
        $error("serial_subtractor: WIDTH must be a multiple of DIGIT");
    end

    // ------------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------------
    state_e r_state;
    state_e w_state_next;

    logic            w_accept;
    logic            w_last;
    logic [CntW-1:0] r_cnt;

    assign w_accept = i_start && ((r_state == StIdle) || (r_state == StDone));
    assign w_last   = (r_state == StRun) && (r_cnt == LastStep);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle: begin
                if (i_start) begin
                    w_state_next = StRun;
                end
            end
            StRun: begin
                if (w_last) begin
                    w_state_next = StDone;
                end
            end
            StDone: begin
                w_state_next = i_start ? StRun : StIdle;
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------------
    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic             r_a_msb;
    logic             r_b_msb;
    logic             r_borrow;
    logic [WIDTH-1:0] r_part;
    logic [WIDTH-1:0] r_diff;
    logic             r_bout;
    logic             r_ovf;

    logic [DIGIT-1:0] w_digit;
    logic             w_digit_bout;
    logic [WIDTH-1:0] w_part_next;

    fs_digit #(
        .DIGIT (DIGIT)
    ) u_fs_digit (
        .i_a    (r_a_sh[DIGIT-1:0]),
        .i_b    (r_b_sh[DIGIT-1:0]),
        .i_bin  (r_borrow),
        .o_d    (w_digit),
        .o_bout (w_digit_bout)
    );

    // New digit enters at the MSB end; after NSTEP shifts the first digit
    // computed has landed in the least-significant position.
    assign w_part_next = WIDTH'({w_digit, r_part} >> DIGIT);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_a_sh   <= '0;
            r_b_sh   <= '0;
            r_a_msb  <= 1'b0;
            r_b_msb  <= 1'b0;
            r_borrow <= 1'b0;
            r_cnt    <= '0;
            r_part   <= '0;
            r_diff   <= '0;
            r_bout   <= 1'b0;
            r_ovf    <= 1'b0;
        end else if (w_accept) begin
            r_a_sh   <= i_a;
            r_b_sh   <= i_b;
            // Sign bits are kept aside because the operand registers are
            // shifted away by the time the overflow is evaluated.
            r_a_msb  <= i_a[WIDTH-1];
            r_b_msb  <= i_b[WIDTH-1];
            r_borrow <= i_bin;
            r_cnt    <= '0;
        end else if (r_state == StRun) begin
            r_a_sh   <= r_a_sh >> DIGIT;
            r_b_sh   <= r_b_sh >> DIGIT;
            r_borrow <= w_digit_bout;
            r_part   <= w_part_next;
            r_cnt    <= r_cnt + 1'b1;
            if (w_last) begin
                r_diff <= w_part_next;
                r_bout <= w_digit_bout;
                // Overflow only when operand signs differ and the result
                // sign departs from the minuend's.
                r_ovf  <= (r_a_msb ^ r_b_msb) & (r_a_msb ^ w_part_next[WIDTH-1]);
            end
        end
    end

    assign o_busy = (r_state == StRun);
    assign o_done = (r_state == StDone);
    assign o_diff = r_diff;
    assign o_bout = r_bout;
    assign o_ovf  = r_ovf;

endmodule

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] a;
    logic [15:0] b;
    logic        bin;
    logic        busy;
    logic        done;
    logic [15:0] diff;
    logic        bout;
    logic        ovf;

    logic        s_start;
    logic [2:0]  s_a;
    logic [2:0]  s_b;
    logic        s_bin;
    logic        s_busy;
    logic        s_done;
    logic [2:0]  s_diff;
    logic        s_bout;
    logic        s_ovf;

    int n_checks;
    int n_fail;

    serial_subtractor #(
        .WIDTH (16),
        .DIGIT (4)
    ) u_dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_start (start),
        .i_a     (a),
        .i_b     (b),
        .i_bin   (bin),
        .o_busy  (busy),
        .o_done  (done),
        .o_diff  (diff),
        .o_bout  (bout),
        .o_ovf   (ovf)
    );

    serial_subtractor #(
        .WIDTH (3),
        .DIGIT (1)
    ) u_dut_small (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_start (s_start),
        .i_a     (s_a),
        .i_b     (s_b),
        .i_bin   (s_bin),
        .o_busy  (s_busy),
        .o_done  (s_done),
        .o_diff  (s_diff),
        .o_bout  (s_bout),
        .o_ovf   (s_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        bin;
        logic [15:0] diff;
        logic        bout;
        logic        ovf;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Called just after an edge; returns edges from accept to done and the
    // number of sampled cycles with busy high.
    task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_v, input logic tbin,
                          output int lat, output int busy_cnt);
        a     = ta;
        b     = tb_v;
        bin   = tbin;
        start = 1'b1;
        @(posedge clk); #1;
        start    = 1'b0;
        lat      = 0;
        busy_cnt = 0;
        while (!done && lat < 20) begin
            if (busy) busy_cnt++;
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic run_small(input int ia, input int ib, input int ic, output int lat);
        s_a     = 3'(ia);
        s_b     = 3'(ib);
        s_bin   = ic[0];
        s_start = 1'b1;
        @(posedge clk); #1;
        s_start = 1'b0;
        lat     = 0;
        while (!s_done && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "simulation timeout");
    end

    initial begin
        int          lat;
        int          bcnt;
        int          gap;
        logic        seen;
        logic [15:0] bb_a   [4];
        logic [15:0] bb_b   [4];
        logic        bb_bin [4];
        logic [15:0] bb_exp [4];

        n_checks = 0;
        n_fail   = 0;

        vecs[0] = '{16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0};
        vecs[1] = '{16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0};
        vecs[2] = '{16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b1, 1'b0};
        vecs[3] = '{16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1};
        vecs[4] = '{16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1};
        vecs[5] = '{16'h0005, 16'h0003, 1'b0, 16'h0002, 1'b0, 1'b0};
        vecs[6] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
        vecs[7] = '{16'hABCD, 16'h1234, 1'b1, 16'h9998, 1'b0, 1'b0};
        vecs[8] = '{16'h1234, 16'h5678, 1'b0, 16'hBBBC, 1'b1, 1'b0};

        rst_n   = 1'b0;
        start   = 1'b0;
        a       = '0;
        b       = '0;
        bin     = 1'b0;
        s_start = 1'b0;
        s_a     = '0;
        s_b     = '0;
        s_bin   = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_diff", diff, 0);
        check("rst_bout", bout, 0);
        check("rst_ovf", ovf, 0);
        check("rst_small_diff", s_diff, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("idle_busy", busy, 0);
        check("idle_done", done, 0);

        // Table-driven single operations
        for (int i = 0; i < 9; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].bin, lat, bcnt);
            check($sformatf("v%0d_latency", i), lat, 4);
            check($sformatf("v%0d_busy_cycles", i), bcnt, 4);
            check($sformatf("v%0d_diff", i), diff, vecs[i].diff);
            check($sformatf("v%0d_bout", i), bout, vecs[i].bout);
            check($sformatf("v%0d_ovf", i), ovf, vecs[i].ovf);
            check($sformatf("v%0d_busy_in_done", i), busy, 0);
            @(posedge clk); #1;
            check($sformatf("v%0d_done_pulse", i), done, 0);
            check($sformatf("v%0d_diff_hold", i), diff, vecs[i].diff);
        end

        // start during RUN is ignored
        a = 16'h8000; b = 16'h0001; bin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        a = 16'h1111; b = 16'h2222; bin = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 2;
        while (!done && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check("ign_latency", lat, 4);
        check("ign_diff", diff, 16'h7FFF);
        check("ign_bout", bout, 0);
        check("ign_ovf", ovf, 1);
        @(posedge clk); #1;
        check("ign_no_requeue", busy, 0);

        // Asynchronous reset in the middle of a RUN
        a = 16'hFFFF; b = 16'h0001; bin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        check("arst_diff", diff, 0);
        check("arst_bout", bout, 0);
        check("arst_ovf", ovf, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        seen  = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
            if (done || busy) seen = 1'b1;
        end
        check("arst_discarded", seen, 0);
        run_op(16'h0005, 16'h0003, 1'b0, lat, bcnt);
        check("arst_after_latency", lat, 4);
        check("arst_after_diff", diff, 16'h0002);
        check("arst_after_bout", bout, 0);
        @(posedge clk); #1;

        // Back-to-back with start held high
        bb_a[0] = 16'h1234; bb_b[0] = 16'h0234; bb_bin[0] = 1'b0; bb_exp[0] = 16'h1000;
        bb_a[1] = 16'h0005; bb_b[1] = 16'h0003; bb_bin[1] = 1'b0; bb_exp[1] = 16'h0002;
        bb_a[2] = 16'hABCD; bb_b[2] = 16'h1234; bb_bin[2] = 1'b1; bb_exp[2] = 16'h9998;
        bb_a[3] = 16'h8000; bb_b[3] = 16'h0001; bb_bin[3] = 1'b0; bb_exp[3] = 16'h7FFF;
        a = bb_a[0]; b = bb_b[0]; bin = bb_bin[0]; start = 1'b1;
        @(posedge clk); #1;
        a = bb_a[1]; b = bb_b[1]; bin = bb_bin[1];
        gap = 0;
        for (int j = 0; j < 4; j++) begin
            while (!done && gap < 20) begin
                @(posedge clk); #1;
                gap++;
            end
            check($sformatf("b2b%0d_interval", j), gap, (j == 0) ? 4 : 5);
            check($sformatf("b2b%0d_diff", j), diff, bb_exp[j]);
            if (j < 3) begin
                @(posedge clk); #1;
                check($sformatf("b2b%0d_hold_diff", j), diff, bb_exp[j]);
                check($sformatf("b2b%0d_done_low", j), done, 0);
                check($sformatf("b2b%0d_busy", j), busy, 1);
                if (j + 2 < 4) begin
                    a = bb_a[j+2]; b = bb_b[j+2]; bin = bb_bin[j+2];
                end else begin
                    start = 1'b0;
                end
                gap = 1;
            end else begin
                start = 1'b0;
            end
        end
        @(posedge clk); #1;

        // Exhaustive WIDTH=3, DIGIT=1
        for (int ia = 0; ia < 8; ia++) begin
            for (int ib = 0; ib < 8; ib++) begin
                for (int ic = 0; ic < 2; ic++) begin
                    int sa;
                    int sb;
                    int r;
                    logic [2:0] exp_d;
                    logic       exp_bo;
                    logic       exp_ov;
                    run_small(ia, ib, ic, lat);
                    exp_d  = 3'((ia - ib - ic) & 7);
                    exp_bo = (ia < ib + ic);
                    sa     = (ia >= 4) ? ia - 8 : ia;
                    sb     = (ib >= 4) ? ib - 8 : ib;
                    r      = sa - sb - ic;
                    exp_ov = (r < -4) || (r > 3);
                    check($sformatf("small_lat a=%0d b=%0d bin=%0d", ia, ib, ic), lat, 3);
                    check($sformatf("small_diff a=%0d b=%0d bin=%0d", ia, ib, ic), s_diff, exp_d);
                    check($sformatf("small_bout a=%0d b=%0d bin=%0d", ia, ib, ic), s_bout, exp_bo);
                    check($sformatf("small_ovf a=%0d b=%0d bin=%0d", ia, ib, ic), s_ovf, exp_ov);
                end
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Digit-serial, parametrised N-bit subtractor computing diff = a − b − bin over WIDTH/DIGIT clock cycles with a registered borrow chain. It is the sequential, multi-bit successor to the single-bit full-subtractor cell: one DIGIT-wide combinational slice is reused every cycle under a start/busy/done handshake. It also reports signed overflow. It sits in the arithmetic datapath where area matters more than latency.

## Interface
- WIDTH, 16, operand and result width in bits; must be a multiple of DIGIT.
- DIGIT, 4, bits processed per cycle; 1 ≤ DIGIT ≤ WIDTH.
- clk  in  1  sole clock; rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request. Sampled only in IDLE or DONE.
- a  in  WIDTH  minuend; captured on the accepting edge.
- b  in  WIDTH  subtrahend; captured on the accepting edge.
- bin  in  1  borrow-in; captured on the accepting edge.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle pulse when the result becomes valid.
- diff  out  WIDTH  result register.
- bout  out  1  final borrow-out (unsigned a < b + bin).
- ovf  out  1  signed two's-complement overflow of a − b − bin.

## Operation
- NSTEP = WIDTH/DIGIT.
- States:
  - IDLE: start=1 → RUN.
  - RUN: the step counter runs 0..NSTEP−1. At the last step → DONE.
  - DONE: lasts one cycle. start=1 → RUN; else → IDLE.
- Accept edge:
  - latches a, b, bin into operand shift registers;
  - borrow register ← bin;
  - step counter ← 0.
- Each RUN edge:
  - processes the low DIGIT bits of the operand registers through fs_digit, using the borrow register as input borrow;
  - shifts the digit result into the partial-result register from the MSB side;
  - shifts the operands right by DIGIT;
  - borrow register ← the slice borrow-out.
- Completion edge (last RUN step):
  - diff ← full partial result;
  - bout ← final borrow;
  - ovf ← (a[MSB]^b[MSB]) & (a[MSB]^diff[MSB]), using the latched a and b.
- diff, bout and ovf are updated only on completion. They hold until the next completion.
- start during RUN is ignored; there is no queueing and the operands are not re-latched.
- Arithmetic is modulo 2^WIDTH. bout equals the borrow out of bit WIDTH−1.
- Reset (any state, including mid-RUN):
  - state → IDLE;
  - busy=0, done=0, diff=0, bout=0, ovf=0;
  - counter, borrow and operand registers cleared;
  - the in-flight operation is discarded.

## Timing
- Accepting edge E0. RUN covers edges E1..E_NSTEP.
- done=1 and the results are valid in the cycle after E_NSTEP. Latency = NSTEP cycles from the accept edge.
- busy=1 from after E0 up to E_NSTEP; it is low in the DONE cycle.
- Back-to-back: start high during DONE is accepted at that edge, giving one result every NSTEP+1 cycles. done is not re-asserted until the new completion.
- DIGIT = WIDTH: NSTEP=1, done one cycle after accept.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Structure
- Shared package arith_pkg holds:
  - the state enum {IDLE, RUN, DONE};
  - a function for the step-counter width, $clog2(NSTEP) with a minimum of 1.
- Sub-module fs_digit (parameter DIGIT):
  - purely combinational ripple of DIGIT full-subtractor bit cells;
  - d_i = a^b^bin;
  - bout_i = (~a&b) | ((~a|b)&bin);
  - ports a, b, bin, d, bout.
- Elaboration-time assertion: WIDTH % DIGIT == 0.

## Test plan
- WIDTH=16, DIGIT=4; a=0x1234, b=0x0234, bin=0 → done after exactly 4 cycles; diff=0x1000, bout=0, ovf=0; busy high for 4 cycles.
- a=0x0000, b=0x0001, bin=0 → diff=0xFFFF, bout=1, ovf=0. Then a=0x0000, b=0x0000, bin=1 → diff=0xFFFF, bout=1, ovf=0.
- a=0x8000, b=0x0001, bin=0 → diff=0x7FFF, bout=0, ovf=1. Also pulse start with other operands during RUN → ignored, result unchanged.
- rst_n low at step 2 of a RUN → all outputs 0 immediately (asynchronous). After release, start with a=5, b=3 → diff=0x0002, bout=0.
- Back-to-back: start held high continuously → completions every 5 cycles with correct diff each time. Between operations, diff holds the previous value.
- WIDTH=3, DIGIT=1, exhaustive over all a, b, bin (128 cases):
  - diff == (a−b−bin) mod 8;
  - bout == (a < b+bin);
  - ovf matches a signed reference model.
